// File: rtl/ext_sram_ctrl.sv
// ext_sram_ctrl: turns each 32-bit busmux word access into byte-wide cycles on
// an external asynchronous 8-bit SRAM. Every byte takes a SETUP cycle, a STROBE
// phase stretched by WAIT_STATES, and a HOLD cycle. The CPU is held through the
// busmux stall input until the DONE cycle, when data_read is valid.
module ext_sram_ctrl #(
  parameter int ADDR_WIDTH  = 19,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_write,
  input  logic [3:0]            data_we,
  input  logic                  cs_n,
  output logic [31:0]           data_read,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_data_o,
  input  logic [7:0]            sram_data_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-3:0] wordAddr_q, wordAddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            pending_q, pending_d;
  logic                  read_q, read_d;
  logic [1:0]            lane_q, lane_d;
  logic [3:0]            wait_q, wait_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            nextLane;
  logic [1:0]            curLane;
  logic                  unusedAddrBits;

  // Byte offset and bits above the SRAM window play no part in the access.
  assign unusedAddrBits = ^{addr[31:ADDR_WIDTH], addr[1:0]};
  assign data_read      = rdata_q;

  // Lowest lane still waiting for its SRAM cycle; unselected write lanes are
  // never in the pending mask, so they cost no cycles at all.
  always_comb begin
    nextLane = 2'd3;
    if (pending_q[0])      nextLane = 2'd0;
    else if (pending_q[1]) nextLane = 2'd1;
    else if (pending_q[2]) nextLane = 2'd2;
  end

  // External address/data bus: SETUP shows the lane being picked, the later
  // phases keep showing the lane that was committed on leaving SETUP.
  always_comb begin
    curLane   = (state_q == SETUP) ? nextLane : lane_q;
    sram_addr = {wordAddr_q, curLane};
    case (curLane)
      2'd0:    sram_data_o = wdata_q[7:0];
      2'd1:    sram_data_o = wdata_q[15:8];
      2'd2:    sram_data_o = wdata_q[23:16];
      default: sram_data_o = wdata_q[31:24];
    endcase
  end

  // State and latched request; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wordAddr_q <= '0;
      wdata_q    <= '0;
      pending_q  <= '0;
      read_q     <= 1'b0;
      lane_q     <= 2'd0;
      wait_q     <= 4'd0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wordAddr_q <= wordAddr_d;
      wdata_q    <= wdata_d;
      pending_q  <= pending_d;
      read_q     <= read_d;
      lane_q     <= lane_d;
      wait_q     <= wait_d;
      rdata_q    <= rdata_d;
    end
  end

  // Sequencer: next state, strobes and CPU stall.
  always_comb begin
    state_d    = state_q;
    wordAddr_d = wordAddr_q;
    wdata_d    = wdata_q;
    pending_d  = pending_q;
    read_d     = read_q;
    lane_d     = lane_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = !cs_n && reset;
        if (!cs_n) begin
          wordAddr_d = addr[ADDR_WIDTH-1:2];
          wdata_d    = data_write;
          read_d     = (data_we == 4'b0000);
          pending_d  = (data_we == 4'b0000) ? 4'b1111 : data_we;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        stall     = 1'b1;
        sram_ce_n = 1'b0;
        lane_d    = nextLane;
        pending_d = pending_q & ~(4'b0001 << nextLane);
        wait_d    = WaitLoad;
        state_d   = STROBE;
      end
      STROBE: begin
        stall     = 1'b1;
        sram_ce_n = 1'b0;
        sram_oe_n = !read_q;
        sram_we_n = read_q;
        if (wait_q == 4'd0) begin
          state_d = HOLD;
          if (read_q) begin
            case (lane_q)
              2'd0:    rdata_d[7:0]   = sram_data_i;
              2'd1:    rdata_d[15:8]  = sram_data_i;
              2'd2:    rdata_d[23:16] = sram_data_i;
              default: rdata_d[31:24] = sram_data_i;
            endcase
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HOLD: begin
        stall     = 1'b1;
        sram_ce_n = 1'b0;
        state_d   = (pending_q != 4'b0000) ? SETUP : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// tb_ext_sram_ctrl: drives two controllers (WAIT_STATES=1 and WAIT_STATES=0),
// each attached to a behavioural byte SRAM, and checks every word access
// against a word-level reference model of the expected byte cycles.
module tb_ext_sram_ctrl;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic [31:0] addr       = '0;
  logic [31:0] data_write = '0;
  logic [3:0]  data_we    = '0;
  logic        csN1       = 1'b1;
  logic        csN0       = 1'b1;

  logic [31:0] dataRead1, dataRead0;
  logic        stall1, stall0;
  logic [18:0] sramAddr1, sramAddr0;
  logic [7:0]  sramDo1, sramDo0, sramDi1, sramDi0;
  logic        ce1, oe1, we1, ce0, oe0, we0;

  logic [7:0]  mem1 [0:1023];
  logic [7:0]  mem0 [0:1023];
  logic [7:0]  ref1 [0:1023];
  logic [7:0]  ref0 [0:1023];
  bit          loadMem = 1'b1;

  int checks = 0;
  int fails  = 0;

  bit          curSel = 1'b1;
  logic        oStall, oCe, oOe, oWe;
  logic [18:0] oAddr;
  logic [7:0]  oDo;
  logic [31:0] oRd;

  int          pLen   [$];
  logic [18:0] pAddr  [$];
  logic [7:0]  pData  [$];
  bit          pWrite [$];
  int          obsCycles, obsCeViol;
  bit          obsTimeout, obsDoneIdle;
  logic [31:0] obsWord;

  logic [18:0] eAddr [$];
  logic [7:0]  eData [$];
  int          eCycles;
  logic [31:0] eWord;
  bit          eWrite;
  logic [31:0] lastRead1 = '0;
  logic [31:0] lastRead0 = '0;

  always #5 clock = ~clock;

  ext_sram_ctrl #(.ADDR_WIDTH(19), .WAIT_STATES(1)) u_dut1 (
    .clock(clock), .reset(reset), .addr(addr), .data_write(data_write),
    .data_we(data_we), .cs_n(csN1), .data_read(dataRead1), .stall(stall1),
    .sram_addr(sramAddr1), .sram_data_o(sramDo1), .sram_data_i(sramDi1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

  ext_sram_ctrl #(.ADDR_WIDTH(19), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset), .addr(addr), .data_write(data_write),
    .data_we(data_we), .cs_n(csN0), .data_read(dataRead0), .stall(stall0),
    .sram_addr(sramAddr0), .sram_data_o(sramDo0), .sram_data_i(sramDi0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0));

  // Asynchronous SRAMs: reads are combinational, writes land while ce/we are low.
  assign sramDi1 = mem1[sramAddr1[9:0]];
  assign sramDi0 = mem0[sramAddr0[9:0]];

  always @(negedge clock) begin
    if (loadMem) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] = ref1[i];
        mem0[i] = ref0[i];
      end
    end else begin
      if (!ce1 && !we1) mem1[sramAddr1[9:0]] = sramDo1;
      if (!ce0 && !we0) mem0[sramAddr0[9:0]] = sramDo0;
    end
  end

  assign oStall = curSel ? stall1    : stall0;
  assign oCe    = curSel ? ce1       : ce0;
  assign oOe    = curSel ? oe1       : oe0;
  assign oWe    = curSel ? we1       : we0;
  assign oAddr  = curSel ? sramAddr1 : sramAddr0;
  assign oDo    = curSel ? sramDo1   : sramDo0;
  assign oRd    = curSel ? dataRead1 : dataRead0;

  // Word-level reference: which byte cycles happen, in what order, what they
  // carry, how long the CPU is stalled and what data_read shows in DONE.
  task automatic modelAccess(input bit sel, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] we);
    int         base;
    int         n;
    logic [3:0] lanes;
    logic [1:0] kk;
    logic [7:0] b;
    base = int'(a[9:2]) * 4;
    n = 0;
    eAddr.delete();
    eData.delete();
    eWrite = (we != 4'b0000);
    lanes  = eWrite ? we : 4'hF;
    eWord  = sel ? lastRead1 : lastRead0;
    for (int k = 0; k < 4; k++) begin
      if (lanes[k]) begin
        kk = 2'(k);
        n++;
        eAddr.push_back({a[18:2], kk});
        if (eWrite) begin
          b = wd[8*k +: 8];
          if (sel) ref1[base+k] = b;
          else     ref0[base+k] = b;
        end else begin
          b = sel ? ref1[base+k] : ref0[base+k];
          eWord[8*k +: 8] = b;
        end
        eData.push_back(b);
      end
    end
    if (!eWrite) begin
      if (sel) lastRead1 = eWord;
      else     lastRead0 = eWord;
    end
    eCycles = 1 + n * ((sel ? 1 : 0) + 3);
  endtask

  // Issues one request and records stall length, strobe pulses and the DONE
  // cycle. cs_n is released after dropAfter cycles (0 keeps it asserted).
  task automatic doAccess(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] we, input int dropAfter);
    bit inPulse;
    bit done;
    inPulse = 1'b0;
    done    = 1'b0;
    curSel  = sel;
    pLen.delete(); pAddr.delete(); pData.delete(); pWrite.delete();
    obsCycles = 0;
    obsCeViol = 0;
    @(posedge clock); #1;
    addr = a; data_write = wd; data_we = we;
    if (sel) csN1 = 1'b0;
    else     csN0 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (!oStall) begin
        done = 1'b1;
        break;
      end
      obsCycles++;
      if (!oOe || !oWe) begin
        if (oCe) obsCeViol++;
        if (!inPulse) begin
          pLen.push_back(1); pAddr.push_back(oAddr);
          pData.push_back(oDo); pWrite.push_back(!oWe);
        end else begin
          pLen[pLen.size()-1] = pLen[pLen.size()-1] + 1;
        end
        inPulse = 1'b1;
      end else begin
        inPulse = 1'b0;
      end
      @(posedge clock); #1;
      if (c + 1 == dropAfter) begin
        csN1 = 1'b1;
        csN0 = 1'b1;
      end
    end
    obsTimeout  = !done;
    obsWord     = oRd;
    obsDoneIdle = oCe && oOe && oWe;
  endtask

  task automatic test_reset();
    addr = $urandom; data_write = $urandom; data_we = 4'($urandom);
    csN1 = 1'b0; csN0 = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (stall1 !== 1'b0 || stall0 !== 1'b0) begin
      fails++; $display("[TB] FAIL reset.stall got %b/%b want 0/0", stall1, stall0);
    end
    checks++;
    if (dataRead1 !== 32'h0 || dataRead0 !== 32'h0) begin
      fails++; $display("[TB] FAIL reset.dataRead got %h/%h want 0", dataRead1, dataRead0);
    end
    checks++;
    if ({ce1, oe1, we1, ce0, oe0, we0} !== 6'b111111) begin
      fails++; $display("[TB] FAIL reset.strobes got %b want 111111", {ce1, oe1, we1, ce0, oe0, we0});
    end
    checks++;
    if (sramAddr1 !== 19'h0 || sramAddr0 !== 19'h0) begin
      fails++; $display("[TB] FAIL reset.sramAddr got %h/%h want 0", sramAddr1, sramAddr0);
    end
    csN1 = 1'b1; csN0 = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    loadMem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (stall1 || stall0 || {ce1, oe1, we1, ce0, oe0, we0} !== 6'b111111) begin
        fails++; $display("[TB] FAIL idleAfterReset cycle %0d got stall %b/%b strobes %b want idle",
                          i, stall1, stall0, {ce1, oe1, we1, ce0, oe0, we0});
      end
    end
  endtask

  task automatic test_read_basic();
    modelAccess(1'b1, 32'h4000_0010, 32'h0, 4'h0);
    doAccess(1'b1, 32'h4000_0010, 32'h0, 4'h0, 1);
    checks++;
    if (obsTimeout || obsCycles != 17) begin
      fails++; $display("[TB] FAIL readBasic.stallCycles got %0d (timeout %b) want 17", obsCycles, obsTimeout);
    end
    checks++;
    if (obsWord !== 32'h44332211) begin
      fails++; $display("[TB] FAIL readBasic.data got %h want 44332211", obsWord);
    end
    checks++;
    if (!obsDoneIdle) begin
      fails++; $display("[TB] FAIL readBasic.doneStrobes got active want idle");
    end
    checks++;
    if (pLen.size() != 4) begin
      fails++; $display("[TB] FAIL readBasic.pulseCount got %0d want 4", pLen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (pAddr[k] !== 19'(32'h10 + k) || pLen[k] != 2 || pWrite[k]) begin
          fails++; $display("[TB] FAIL readBasic.pulse%0d got addr %h len %0d wr %b want addr %h len 2 wr 0",
                            k, pAddr[k], pLen[k], pWrite[k], 19'(32'h10 + k));
        end
      end
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] old21, old23;
    old21 = ref1[32'h21];
    old23 = ref1[32'h23];
    modelAccess(1'b1, 32'h4000_0020, 32'hAABBCCDD, 4'b0101);
    doAccess(1'b1, 32'h4000_0020, 32'hAABBCCDD, 4'b0101, 1);
    checks++;
    if (obsTimeout || obsCycles != 9) begin
      fails++; $display("[TB] FAIL partialWrite.stallCycles got %0d want 9", obsCycles);
    end
    checks++;
    if (pLen.size() != 2) begin
      fails++; $display("[TB] FAIL partialWrite.pulseCount got %0d want 2", pLen.size());
    end else begin
      checks++;
      if (pAddr[0] !== 19'h20 || pData[0] !== 8'hDD || !pWrite[0] || pLen[0] != 2) begin
        fails++; $display("[TB] FAIL partialWrite.pulse0 got %h/%h len %0d want 20/DD len 2", pAddr[0], pData[0], pLen[0]);
      end
      checks++;
      if (pAddr[1] !== 19'h22 || pData[1] !== 8'hBB || !pWrite[1] || pLen[1] != 2) begin
        fails++; $display("[TB] FAIL partialWrite.pulse1 got %h/%h len %0d want 22/BB len 2", pAddr[1], pData[1], pLen[1]);
      end
    end
    checks++;
    if ({mem1[32'h23], mem1[32'h22], mem1[32'h21], mem1[32'h20]} !== {old23, 8'hBB, old21, 8'hDD}) begin
      fails++; $display("[TB] FAIL partialWrite.memory got %h want %h",
                        {mem1[32'h23], mem1[32'h22], mem1[32'h21], mem1[32'h20]}, {old23, 8'hBB, old21, 8'hDD});
    end
    checks++;
    if (obsWord !== 32'h44332211) begin
      fails++; $display("[TB] FAIL partialWrite.dataReadRetained got %h want 44332211", obsWord);
    end
  endtask

  // Random (or fixed) accesses checked in full against the reference model.
  task automatic test_random_traffic(input int count, input int mode);
    bit          sel;
    logic [31:0] a, wd;
    logic [3:0]  we;
    int          drop;
    int          base;
    for (int i = 0; i < count; i++) begin
      sel  = (mode == 0) ? i[0] : (mode == 1);
      a    = 32'h4000_0000 | (32'($urandom_range(0, 255)) << 2);
      wd   = $urandom;
      we   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drop = 1;
      if (mode == 1) begin
        we   = (i == 0) ? 4'h0 : 4'hF;
        drop = (i == 0) ? 0 : 1;
      end else if (mode == 2) begin
        we   = 4'h0;
        drop = 3;
      end
      base = int'(a[9:2]) * 4;
      modelAccess(sel, a, wd, we);
      doAccess(sel, a, wd, we, drop);
      checks++;
      if (obsTimeout || obsCycles != eCycles) begin
        fails++; $display("[TB] FAIL traffic%0d.%0d.stallCycles got %0d (timeout %b) want %0d",
                          mode, i, obsCycles, obsTimeout, eCycles);
      end
      checks++;
      if (obsWord !== eWord || !obsDoneIdle || obsCeViol != 0) begin
        fails++; $display("[TB] FAIL traffic%0d.%0d.done got data %h idle %b ceViol %0d want data %h idle 1 ceViol 0",
                          mode, i, obsWord, obsDoneIdle, obsCeViol, eWord);
      end
      checks++;
      if (pLen.size() != eAddr.size()) begin
        fails++; $display("[TB] FAIL traffic%0d.%0d.pulseCount got %0d want %0d", mode, i, pLen.size(), eAddr.size());
      end else begin
        for (int k = 0; k < eAddr.size(); k++) begin
          checks++;
          if (pAddr[k] !== eAddr[k] || pWrite[k] != eWrite || pLen[k] != (sel ? 2 : 1) ||
              (eWrite && pData[k] !== eData[k])) begin
            fails++; $display("[TB] FAIL traffic%0d.%0d.pulse%0d got %h/%h wr %b len %0d want %h/%h wr %b len %0d",
                              mode, i, k, pAddr[k], pData[k], pWrite[k], pLen[k],
                              eAddr[k], eData[k], eWrite, sel ? 2 : 1);
          end
        end
      end
      if (eWrite) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if ((sel ? mem1[base+k] : mem0[base+k]) !== (sel ? ref1[base+k] : ref0[base+k])) begin
            fails++; $display("[TB] FAIL traffic%0d.%0d.memByte%0d got %h want %h", mode, i, k,
                              sel ? mem1[base+k] : mem0[base+k], sel ? ref1[base+k] : ref0[base+k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random_traffic(2, 1);
  endtask

  task automatic test_zero_wait();
    test_random_traffic(2, 2);
  endtask

  task automatic test_reset_mid_strobe();
    logic [31:0] wd;
    logic [7:0]  old2, old3;
    bit          found;
    bit          idleViol;
    wd    = $urandom;
    old2  = ref1[32'h42];
    old3  = ref1[32'h43];
    found = 1'b0;
    curSel = 1'b1;
    @(posedge clock); #1;
    addr = 32'h4000_0040; data_write = wd; data_we = 4'hF; csN1 = 1'b0;
    @(posedge clock); #1;
    csN1 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!ce1 && we1 && oe1 && sramAddr1[1:0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    checks++;
    if (!found || we1 !== 1'b0 || sramAddr1 !== 19'h42) begin
      fails++; $display("[TB] FAIL resetMid.reachLane2 got found %b we %b addr %h want 1/0/42", found, we1, sramAddr1);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ce1, oe1, we1} !== 3'b111 || stall1 !== 1'b0) begin
      fails++; $display("[TB] FAIL resetMid.abort got strobes %b stall %b want 111/0", {ce1, oe1, we1}, stall1);
    end
    lastRead1 = '0;
    lastRead0 = '0;
    ref1[32'h40] = wd[7:0];
    ref1[32'h41] = wd[15:8];
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idleViol = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (stall1 || {ce1, oe1, we1} !== 3'b111 || dataRead1 !== 32'h0) idleViol = 1'b1;
    end
    checks++;
    if (idleViol) begin
      fails++; $display("[TB] FAIL resetMid.idleAfterRelease got activity want idle with data_read 0");
    end
    checks++;
    if ({mem1[32'h43], mem1[32'h42], mem1[32'h41], mem1[32'h40]} !== {old3, old2, wd[15:0]}) begin
      fails++; $display("[TB] FAIL resetMid.memory got %h want %h",
                        {mem1[32'h43], mem1[32'h42], mem1[32'h41], mem1[32'h40]}, {old3, old2, wd[15:0]});
    end
  endtask

  // Guard against a controller that never releases the bus.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref1[i] = 8'($urandom);
      ref0[i] = 8'($urandom);
    end
    ref1[32'h10] = 8'h11; ref1[32'h11] = 8'h22;
    ref1[32'h12] = 8'h33; ref1[32'h13] = 8'h44;
    test_reset();
    test_read_basic();
    test_partial_write();
    test_back_to_back();
    test_zero_wait();
    test_random_traffic(14, 0);
    test_reset_mid_strobe();
    test_random_traffic(4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ext_sram_ctrl.md
Name: ext_sram_ctrl

Overview:
- Memory-side stage between the busmux memory port (addr_mem/data_read_mem/data_write_mem/data_we_mem) and an external 8-bit asynchronous SRAM. Used in place of the on-chip bram banks for the RAM region.
- Splits each 32-bit word access into byte-wide SRAM cycles with programmable wait states.
- Holds the CPU through the busmux stall input until the word completes.

Parameters:
- ADDR_WIDTH, 19, external SRAM byte-address width; word index = addr[ADDR_WIDTH-1:2].
- WAIT_STATES, 1, extra strobe cycles per byte; legal range 0..15.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  word address from busmux (addr_mem).
- data_write  in  32  write data (data_write_mem).
- data_we  in  4  byte write enables; bit k = byte lane [8k+7:8k]; all zero means read.
- cs_n  in  1  active-low request, decoded from the RAM address region.
- data_read  out  32  assembled read word (to data_read_mem).
- stall  out  1  high while an access is in progress; drives the busmux stall input.
- sram_addr  out  ADDR_WIDTH  external byte address.
- sram_data_o  out  8  external write data.
- sram_data_i  in  8  external read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  external strobes, active-low.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, data_read=0, stall=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_addr=0, sram_data_o=0, latched request cleared.
  - Reset asserted mid-transaction aborts it immediately. No partial completion after release.
- States:
  - IDLE
  - SETUP: computes the next active lane.
  - STROBE: WAIT_STATES+1 cycles; wait counter 4 bits.
  - HOLD: 1 cycle.
  - DONE: 1 cycle.
- IDLE:
  - When cs_n=0, stall goes high combinationally in that same cycle.
  - On the clock edge: latch addr, data_write and data_we; set read flag = (data_we==0); go to SETUP.
- Lane order: 0,1,2,3.
  - Read: all four lanes.
  - Write: only lanes with data_we[k]=1, skipped in zero cycles; SETUP selects the lowest remaining set bit.
  - No read-modify-write.
- SETUP (1 cycle):
  - sram_addr = {latched addr[ADDR_WIDTH-1:2], k[1:0]}.
  - sram_data_o = latched byte k.
  - sram_ce_n=0; all other strobes high (address setup).
- STROBE:
  - sram_ce_n=0.
  - Read: sram_oe_n=0. Write: sram_we_n=0.
  - On the final STROBE edge a read captures sram_data_i into data_read[8k+7:8k].
- HOLD:
  - sram_oe_n=sram_we_n=1; ce_n, address and data held.
  - Then SETUP if lanes remain, otherwise DONE.
- DONE:
  - stall=0; strobes inactive; data_read valid.
  - The busmux samples data_read this cycle.
  - Next state is IDLE unconditionally. A cs_n=0 in the following IDLE cycle is a new request.
- stall equation: high in SETUP/STROBE/HOLD, and in IDLE when cs_n=0. Low in DONE and when idle without request.
- Stall cycles:
  - Read: 1 + 4*(WAIT_STATES+3).
  - Write: 1 + n*(WAIT_STATES+3), where n = popcount(data_we).
- data_read:
  - Retains the last read word across writes and idle.
  - Bytes of a read are overwritten lane by lane. Only the DONE-cycle value is architecturally valid.
- cs_n changes after the request is latched are ignored; the transaction always completes. addr, data_write and data_we are not resampled.
- Wait counter reloads to WAIT_STATES on every entry to STROBE.
  - WAIT_STATES=0 gives a 1-cycle STROBE.
  - No wrap beyond 15.

Test Plan:
- Reset: hold reset=0 with cs_n=0 and random inputs -> stall=0, data_read=0, all three strobes =1. After release, idle until a request arrives.
- Read, WAIT_STATES=1, addr=0x40000010, SRAM bytes at 0x10..0x13 = 11,22,33,44 -> sram_addr sequence 0x10,0x11,0x12,0x13; stall high for 17 cycles; DONE shows data_read=0x44332211; each oe_n low pulse is 2 cycles.
- Partial write, data_we=4'b0101, data_write=0xAABBCCDD, addr=0x40000020 -> exactly two we_n pulses: address 0x20 with data 0xDD, address 0x22 with data 0xBB; stall high 9 cycles; bytes 0x21 and 0x23 untouched.
- Back-to-back: cs_n held 0 for a read then a full write (data_we=4'hF) -> DONE cycle with stall=0 between them; the second request is latched in the following IDLE cycle; no lost or duplicated SRAM cycles.
- Reset mid-STROBE of lane 2 of a write -> strobes go inactive immediately; lane 3 is never written; after release, state IDLE and stall=0.
- WAIT_STATES=0 read -> stall high 13 cycles, each oe_n pulse 1 cycle, data assembled correctly; cs_n deasserted mid-access still completes all 4 lanes.
